// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm,
//            one quotient bit per cycle. Drives the register-file write port.
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic [4:0]       i_rd,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_load,
  output logic [4:0]       o_rd,
  output logic [WIDTH-1:0] o_result
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;

  // Operand decode of the incoming instruction (used only on the start edge)
  logic             op_signed, op_rem;
  logic             rs1_neg, rs2_neg;
  logic             div_zero, sgn_ovf, take_early;
  logic [WIDTH-1:0] rs1_mag, rs2_mag, early_val;

  // One restoring step and the final sign fix-up
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Decode the request and precompute special-case results
  always_comb begin
    op_signed  = (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    op_rem     = i_funct3[2] & i_funct3[1];
    rs1_neg    = op_signed & i_rs1[WIDTH-1];
    rs2_neg    = op_signed & i_rs2[WIDTH-1];
    rs1_mag    = rs1_neg ? -i_rs1 : i_rs1;
    rs2_mag    = rs2_neg ? -i_rs2 : i_rs2;
    div_zero   = (i_rs2 == '0);
    sgn_ovf    = op_signed && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    take_early = (EARLY_OUT != 0) && (div_zero || sgn_ovf);
    if (div_zero) begin
      early_val = op_rem ? i_rs1 : '1;
    end else begin
      early_val = op_rem ? '0 : i_rs1;
    end
  end

  // Restoring iteration datapath and sign correction
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  // Next-state logic; flush overrides every transition including a start
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            rd_d     = i_rd;
            is_rem_d = op_rem;
            // A zero divisor must leave the all-ones quotient unsigned-looking
            neg_quo_d = (rs1_neg ^ rs2_neg) & ~div_zero;
            neg_rem_d = rs1_neg;
            rem_d     = '0;
            quo_d     = rs1_mag;
            dvs_d     = rs2_mag;
            cnt_d     = CNT_W'(WIDTH - 1);
            if (take_early) begin
              result_d = early_val;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
          end
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  // Outputs decode directly from registered state
  always_comb begin
    o_busy   = (state_q != S_IDLE);
    o_done   = (state_q == S_DONE);
    o_load   = (state_q == S_DONE);
    o_rd     = rd_q;
    o_result = result_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed self-checking bench for div_unit; runs an EARLY_OUT=1
//            and an EARLY_OUT=0 instance side by side on shared operands.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start_eo, start_fl;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;

  logic        busy_eo, done_eo, load_eo;
  logic [4:0]  rd_eo;
  logic [31:0] res_eo;
  logic        busy_fl, done_fl, load_fl;
  logic [4:0]  rd_fl;
  logic [31:0] res_fl;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(.WIDTH(32), .EARLY_OUT(1)) u_dut_eo (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_eo), .i_funct3(funct3),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_flush(flush),
    .o_busy(busy_eo), .o_done(done_eo), .o_load(load_eo),
    .o_rd(rd_eo), .o_result(res_eo)
  );

  div_unit #(.WIDTH(32), .EARLY_OUT(0)) u_dut_fl (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_fl), .i_funct3(funct3),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_flush(flush),
    .o_busy(busy_fl), .o_done(done_fl), .o_load(load_fl),
    .o_rd(rd_fl), .o_result(res_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start an op on both instances at cycle 0 and watch 40 cycles.
  // disturb > 0 pulses a second start (full-latency instance only) in that cycle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rdi, input logic [31:0] exp,
                        input int lat_eo, input int lat_fl, input int disturb);
    int cnt_eo = 0;
    int cnt_fl = 0;
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd = rdi; start_eo = 1'b1; start_fl = 1'b1;
    @(posedge clk);
    #1;
    start_eo = 1'b0; start_fl = 1'b0;
    funct3 = 3'b100; rs1 = 32'hDEADBEEF; rs2 = 32'h3; rd = 5'd31;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_eo) begin
        cnt_eo++;
        check({name, " eo latency"}, 32'(c), 32'(lat_eo));
        check({name, " eo result"}, res_eo, exp);
        check({name, " eo rd"}, {27'd0, rd_eo}, {27'd0, rdi});
        check({name, " eo load"}, {31'd0, load_eo}, 32'd1);
      end
      if (done_fl) begin
        cnt_fl++;
        check({name, " fl latency"}, 32'(c), 32'(lat_fl));
        check({name, " fl result"}, res_fl, exp);
        check({name, " fl rd"}, {27'd0, rd_fl}, {27'd0, rdi});
        check({name, " fl load"}, {31'd0, load_fl}, 32'd1);
      end
      if (c == disturb) begin
        start_fl = 1'b1; funct3 = 3'b101; rs1 = 32'h12345678; rs2 = 32'h9; rd = 5'd7;
      end else begin
        start_fl = 1'b0;
      end
    end
    check({name, " eo done count"}, 32'(cnt_eo), 32'd1);
    check({name, " fl done count"}, 32'(cnt_fl), 32'd1);
  endtask

  // Stimulus
  initial begin
    int cnt;
    rst_n = 1'b0; start_eo = 1'b0; start_fl = 1'b0; funct3 = 3'b000;
    rs1 = '0; rs2 = '0; rd = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy_fl}, 32'd0);
    check("reset done", {31'd0, done_fl}, 32'd0);
    check("reset load", {31'd0, load_eo}, 32'd0);
    check("reset rd", {27'd0, rd_fl}, 32'd0);
    check("reset result", res_eo, 32'd0);
    rst_n = 1'b1;

    // Basic unsigned and signed results
    run_op("divu 100/7",   3'b101, 32'd100,        32'd7,          5'd1,  32'd14,         34, 34, 0);
    run_op("remu 100/7",   3'b111, 32'd100,        32'd7,          5'd2,  32'd2,          34, 34, 0);
    run_op("div -7/2",     3'b100, 32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD,   34, 34, 0);
    run_op("rem -7/2",     3'b110, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   34, 34, 0);
    run_op("remu 7/-1",    3'b111, 32'd7,          32'hFFFFFFFF,   5'd5,  32'd7,          34, 34, 0);
    run_op("div 100/-7",   3'b100, 32'd100,        32'hFFFFFFF9,   5'd6,  32'hFFFFFFF2,   34, 34, 0);
    run_op("rem 100/-7",   3'b110, 32'd100,        32'hFFFFFFF9,   5'd8,  32'd2,          34, 34, 0);
    run_op("f3=000 divu",  3'b000, 32'hFFFFFFF9,   32'd2,          5'd9,  32'h7FFFFFFC,   34, 34, 0);
    // Divide by zero and signed overflow
    run_op("divu 5/0",     3'b101, 32'd5,          32'd0,          5'd10, 32'hFFFFFFFF,   1,  34, 0);
    run_op("remu 5/0",     3'b111, 32'd5,          32'd0,          5'd11, 32'd5,          1,  34, 0);
    run_op("div -5/0",     3'b100, 32'hFFFFFFFB,   32'd0,          5'd12, 32'hFFFFFFFF,   1,  34, 0);
    run_op("rem -5/0",     3'b110, 32'hFFFFFFFB,   32'd0,          5'd13, 32'hFFFFFFFB,   1,  34, 0);
    run_op("div ovf",      3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd14, 32'h80000000,   1,  34, 0);
    run_op("rem ovf",      3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd15, 32'd0,          1,  34, 0);
    // Start while busy is ignored
    run_op("busy start",   3'b101, 32'd1000,       32'd3,          5'd16, 32'd333,        34, 34, 10);

    // Reset in mid-operation
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd17; start_eo = 1'b1; start_fl = 1'b1;
    @(posedge clk);
    #1;
    start_eo = 1'b0; start_fl = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst busy eo", {31'd0, busy_eo}, 32'd0);
    check("rst busy fl", {31'd0, busy_fl}, 32'd0);
    check("rst rd fl", {27'd0, rd_fl}, 32'd0);
    check("rst result fl", res_fl, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_eo || done_fl) cnt++;
    end
    check("rst no done", 32'(cnt), 32'd0);
    run_op("post-rst divu", 3'b101, 32'd200,       32'd7,          5'd18, 32'd28,         34, 34, 0);

    // Flush in mid-operation keeps the previous result
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd500; rs2 = 32'd7; rd = 5'd19; start_eo = 1'b1; start_fl = 1'b1;
    @(posedge clk);
    #1;
    start_eo = 1'b0; start_fl = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy eo", {31'd0, busy_eo}, 32'd0);
    check("flush busy fl", {31'd0, busy_fl}, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_eo || done_fl) cnt++;
    end
    check("flush no done", 32'(cnt), 32'd0);
    check("flush result eo", res_eo, 32'd28);
    check("flush result fl", res_fl, 32'd28);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
